// File: rtl/fetch_queue_pkg.sv
// Shared widths, defaults and queue entry layout for the instruction-fetch front end.
package fetch_queue_pkg;

  localparam int unsigned WORD            = 64;
  localparam int unsigned INSTR_LEN       = 32;
  localparam int unsigned FQ_DEPTH        = 4;
  localparam int unsigned PC_STEP_DEFAULT = 4;

  typedef struct packed {
    logic [WORD-1:0]      pc;
    logic [INSTR_LEN-1:0] instr;
  } fq_entry_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Redirect, instruction-memory and decode handshakes of the fetch queue.
interface fetch_queue_if;

  logic                                 redirect_valid;
  logic [fetch_queue_pkg::WORD-1:0]      redirect_target;
  logic                                 imem_req_valid;
  logic                                 imem_req_ready;
  logic [fetch_queue_pkg::WORD-1:0]      imem_req_addr;
  logic                                 imem_rsp_valid;
  logic [fetch_queue_pkg::INSTR_LEN-1:0] imem_rsp_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [fetch_queue_pkg::INSTR_LEN-1:0] out_instr;
  logic [fetch_queue_pkg::WORD-1:0]      out_pc;

  modport master (
    input  redirect_valid,
    input  redirect_target,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    output redirect_valid,
    output redirect_target,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/clear and occupancy; Depth must be a power of two.
module fetch_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AddrW + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AddrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (AddrW + 1)'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - (AddrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: owns the fetch PC, issues credit-limited requests and queues
// in-order responses for decode; a redirect flushes the queue and squashes in-flight replies.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     Depth   = FQ_DEPTH,
  parameter logic [WORD-1:0] ResetPc = '0,
  parameter logic [WORD-1:0] PcStep  = WORD'(PC_STEP_DEFAULT)
) (
  input logic            clk,
  input logic            rst_n,
  fetch_queue_if.master  bus
);

  localparam int unsigned CntW = cnt_width(Depth);

  logic [WORD-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] squash_q, squash_d;
  logic [CntW-1:0] q_count, pc_count;
  logic [CntW:0]   credits_used;
  logic            active_q;
  logic            req_fire, rsp_ok, rsp_keep, q_pop;
  logic            q_empty, q_full, pc_full, pc_empty;
  logic [WORD-1:0] rsp_pc;
  fq_entry_t       q_wdata, q_head;
  logic            unused_status;

  // Every queued entry and every outstanding request holds one credit, so the queue
  // can never overflow. active_q keeps requests off until the first edge after reset.
  assign credits_used        = {1'b0, q_count} + {1'b0, inflight_q};
  assign bus.imem_req_valid  = active_q && !bus.redirect_valid &&
                               (credits_used < (CntW + 1)'(Depth));
  assign bus.imem_req_addr   = fetch_pc_q;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_ok   = bus.imem_rsp_valid && (inflight_q != '0);
  assign rsp_keep = rsp_ok && (squash_q == '0) && !bus.redirect_valid;
  assign q_pop    = bus.out_valid && bus.out_ready && !bus.redirect_valid;
  assign q_wdata  = '{pc: rsp_pc, instr: bus.imem_rsp_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CntW'(req_fire) - CntW'(rsp_ok);
    squash_d   = squash_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_target;
      squash_d   = inflight_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PcStep;
      end
      if (rsp_ok && (squash_q != '0)) begin
        squash_d = squash_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= ResetPc;
      inflight_q <= '0;
      squash_q   <= '0;
      active_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
      active_q   <= 1'b1;
    end
  end

  // PCs of outstanding requests, consumed in order as responses (kept or dropped) return.
  fetch_fifo #(
    .Width (WORD),
    .Depth (Depth)
  ) u_pc_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .pop   (rsp_ok),
    .clear (1'b0),
    .wdata (fetch_pc_q),
    .rdata (rsp_pc),
    .count (pc_count),
    .full  (pc_full),
    .empty (pc_empty)
  );

  fetch_fifo #(
    .Width ($bits(fq_entry_t)),
    .Depth (Depth)
  ) u_out_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .pop   (q_pop),
    .clear (bus.redirect_valid),
    .wdata (q_wdata),
    .rdata (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign bus.out_valid = !q_empty;
  assign bus.out_pc    = q_head.pc;
  assign bus.out_instr = q_head.instr;

  assign unused_status = ^{pc_count, pc_full, pc_empty, q_full};

endmodule
